// File: rtl/rx_frame_pkg.sv
// Shared types and helpers for the receive frame synchroniser.
package rx_frame_pkg;

  localparam logic [31:0] SYNC_WORD_DEF = 32'h1ACF_FC1D;
  localparam int          SYNC_LEN_DEF  = 32;

  typedef enum logic {
    HUNT    = 1'b0,
    PAYLOAD = 1'b1
  } state_e;

  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] c;
    c = '0;
    for (int i = 0; i < 32; i++) c = c + 6'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/sync_correlator.sv
// Sync-word shift register and Hamming-distance compare.
// RX_FRAME_INV_DET_EN adds the inverted-polarity compare.
module sync_correlator
  import rx_frame_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD = SYNC_WORD_DEF,
  parameter int          SYNC_LEN  = SYNC_LEN_DEF,
  parameter int          MAX_ERR   = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic hunt_i,
  input  logic bit_i,
  input  logic vld_i,
  output logic match_o,
  output logic match_inv_o
);

  localparam logic [SYNC_LEN-1:0] SYNC = SYNC_WORD[SYNC_LEN-1:0];

  logic [SYNC_LEN-2:0] sr_q, sr_d;
  logic [SYNC_LEN-1:0] cand;
  logic                hit, hit_inv;

  assign cand = {sr_q, bit_i};
  assign hit  = popcount(32'(cand ^ SYNC)) <= 6'(MAX_ERR);

`ifdef RX_FRAME_INV_DET_EN
  assign hit_inv = popcount(32'(cand ^ ~SYNC)) <= 6'(MAX_ERR);
`else
  assign hit_inv = 1'b0;
`endif

  // True polarity wins when both compares hit.
  assign match_o     = hunt_i & vld_i & hit;
  assign match_inv_o = hunt_i & vld_i & hit_inv & ~hit;

  // Held at zero outside HUNT so every hunt starts from a clean window.
  always_comb begin
    sr_d = sr_q;
    if (!hunt_i || match_o || match_inv_o) sr_d = '0;
    else if (vld_i)                        sr_d = cand[SYNC_LEN-2:0];
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sr_q <= '0;
    else         sr_q <= sr_d;
  end

endmodule

// File: rtl/rx_frame_sync.sv
// Frame synchroniser and byte deserialiser with single-entry AXI-Stream output.
// RX_FRAME_INV_DET_EN enables inverted-sync detection and payload complementing.
module rx_frame_sync
  import rx_frame_pkg::*;
#(
  parameter logic [31:0] SYNC_WORD     = SYNC_WORD_DEF,
  parameter int          SYNC_LEN      = SYNC_LEN_DEF,
  parameter int          MAX_ERR       = 2,
  parameter int          PAYLOAD_BYTES = 16
) (
  input  logic        clk_32M768,
  input  logic        rst_n_32M768,
  input  logic        bit_in,
  input  logic        bit_vld,
  output logic [7:0]  m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tuser,
  output logic        m_tlast,
  output logic        locked,
  output logic        inverted,
  output logic [15:0] frame_cnt,
  output logic        ovf
);

  state_e      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  byte_cnt_q, byte_cnt_d;
  logic [6:0]  shreg_q, shreg_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;
  logic [7:0]  tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tuser_q, tuser_d;
  logic        tlast_q, tlast_d;
  logic        ovf_q, ovf_d;

  logic match, match_inv, lock, inv_w, pbit, byte_done, last_byte;

  sync_correlator #(
    .SYNC_WORD (SYNC_WORD),
    .SYNC_LEN  (SYNC_LEN),
    .MAX_ERR   (MAX_ERR)
  ) u_corr (
    .clk_i       (clk_32M768),
    .rst_ni      (rst_n_32M768),
    .hunt_i      (state_q == HUNT),
    .bit_i       (bit_in),
    .vld_i       (bit_vld),
    .match_o     (match),
    .match_inv_o (match_inv)
  );

  assign lock = match | match_inv;

`ifdef RX_FRAME_INV_DET_EN
  logic inv_q;
  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768) inv_q <= 1'b0;
    else if (lock)     inv_q <= match_inv;
  end
  assign inv_w = inv_q;
`else
  assign inv_w = 1'b0;
`endif

  assign pbit      = bit_in ^ inv_w;
  assign last_byte = byte_cnt_q == 8'(PAYLOAD_BYTES - 1);
  assign byte_done = (state_q == PAYLOAD) && bit_vld && (bit_cnt_q == 3'd7);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    byte_cnt_d  = byte_cnt_q;
    shreg_d     = shreg_q;
    frame_cnt_d = frame_cnt_q;
    tdata_d     = tdata_q;
    tvalid_d    = tvalid_q;
    tuser_d     = tuser_q;
    tlast_d     = tlast_q;
    ovf_d       = ovf_q;

    case (state_q)
      HUNT: begin
        if (lock) begin
          state_d     = PAYLOAD;
          frame_cnt_d = frame_cnt_q + 16'd1;
          bit_cnt_d   = '0;
          byte_cnt_d  = '0;
          shreg_d     = '0;
        end
      end
      PAYLOAD: begin
        if (bit_vld) begin
          shreg_d   = {shreg_q[5:0], pbit};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            byte_cnt_d = byte_cnt_q + 8'd1;
            if (last_byte) state_d = HUNT;
          end
        end
      end
      default: state_d = HUNT;
    endcase

    if (tvalid_q && m_tready) tvalid_d = 1'b0;
    // A completing byte overwrites only if the held one is leaving this cycle.
    if (byte_done) begin
      if (tvalid_q && !m_tready) begin
        ovf_d = 1'b1;
      end else begin
        tdata_d  = {shreg_q, pbit};
        tvalid_d = 1'b1;
        tuser_d  = byte_cnt_q == 8'd0;
        tlast_d  = last_byte;
      end
    end
  end

  always_ff @(posedge clk_32M768) begin
    if (!rst_n_32M768) begin
      state_q     <= HUNT;
      bit_cnt_q   <= '0;
      byte_cnt_q  <= '0;
      shreg_q     <= '0;
      frame_cnt_q <= '0;
      tdata_q     <= '0;
      tvalid_q    <= 1'b0;
      tuser_q     <= 1'b0;
      tlast_q     <= 1'b0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      byte_cnt_q  <= byte_cnt_d;
      shreg_q     <= shreg_d;
      frame_cnt_q <= frame_cnt_d;
      tdata_q     <= tdata_d;
      tvalid_q    <= tvalid_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      ovf_q       <= ovf_d;
    end
  end

  assign m_tdata   = tdata_q;
  assign m_tvalid  = tvalid_q;
  assign m_tuser   = tuser_q;
  assign m_tlast   = tlast_q;
  assign locked    = state_q == PAYLOAD;
  assign inverted  = inv_w;
  assign frame_cnt = frame_cnt_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_rx_frame_sync.sv
// Randomised bench for rx_frame_sync: bit-stream reference model feeds a byte scoreboard.
module tb_rx_frame_sync;

  localparam logic [31:0] SYNC = 32'h1ACF_FC1D;
  localparam int          N    = 16;
  localparam int          MAXE = 2;

  logic        clk = 1'b0, rst_n = 1'b0, bit_in = 1'b0, bit_vld = 1'b0, m_tready = 1'b1;
  logic [7:0]  m_tdata;
  logic        m_tvalid, m_tuser, m_tlast, locked, inverted, ovf;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  rx_frame_sync dut (
    .clk_32M768   (clk),
    .rst_n_32M768 (rst_n),
    .bit_in       (bit_in),
    .bit_vld      (bit_vld),
    .m_tdata      (m_tdata),
    .m_tvalid     (m_tvalid),
    .m_tready     (m_tready),
    .m_tuser      (m_tuser),
    .m_tlast      (m_tlast),
    .locked       (locked),
    .inverted     (inverted),
    .frame_cnt    (frame_cnt),
    .ovf          (ovf)
  );

  typedef struct packed {
    logic [7:0] d;
    logic       u;
    logic       l;
  } beat_t;

  beat_t expq[$];
  int    total = 0, bad = 0;
  int    gap = 16, rdy_low = 0;

  // Reference model: sliding window while hunting, count of payload bits otherwise.
  logic [31:0] m_win;
  int          m_left, m_idx;
  logic [7:0]  m_acc, m_held;
  logic        m_inv, m_ovf, m_hold;
  logic [15:0] m_fc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_win = '0; m_left = 0; m_idx = 0; m_acc = '0; m_held = '0;
    m_inv = 1'b0; m_ovf = 1'b0; m_hold = 1'b0; m_fc = '0;
    expq.delete();
  endtask

  task automatic model_bit(input logic b);
    logic [31:0] cand;
    beat_t       bt;
    if (m_left == 0) begin
      cand = {m_win[30:0], b};
      if ($countones(cand ^ SYNC) <= MAXE) begin
        m_fc++; m_inv = 1'b0; m_left = 8 * N; m_idx = 0; m_win = '0;
      end
`ifdef RX_FRAME_INV_DET_EN
      else if ($countones(cand ^ ~SYNC) <= MAXE) begin
        m_fc++; m_inv = 1'b1; m_left = 8 * N; m_idx = 0; m_win = '0;
      end
`endif
      else m_win = cand;
    end else begin
      m_acc = {m_acc[6:0], b ^ m_inv};
      m_left--;
      if (m_left % 8 == 0) begin
        bt.d = m_acc; bt.u = (m_idx == 0); bt.l = (m_idx == N - 1);
        if (!m_tready && m_hold) m_ovf = 1'b1;
        else begin
          expq.push_back(bt);
          if (!m_tready) begin m_hold = 1'b1; m_held = m_acc; end
        end
        m_idx++;
      end
      if (m_left == 0) m_win = '0;
    end
  endtask

  task automatic send_bit(input logic b);
    @(posedge clk); #1;
    bit_in = b; bit_vld = 1'b1;
    model_bit(b);
    @(posedge clk); #1;
    bit_vld = 1'b0;
    chk("locked", {31'd0, locked}, {31'd0, m_left != 0});
    chk("frame_cnt", {16'd0, frame_cnt}, {16'd0, m_fc});
    chk("inverted", {31'd0, inverted}, {31'd0, m_inv});
    chk("ovf", {31'd0, ovf}, {31'd0, m_ovf});
    if (!m_tready && m_hold) begin
      chk("held_valid", {31'd0, m_tvalid}, 32'd1);
      chk("held_data", {24'd0, m_tdata}, {24'd0, m_held});
    end
    for (int i = 2; i < gap; i++) begin
      @(posedge clk); #1;
      if (i == gap / 2 && rdy_low > 0) begin
        rdy_low--;
        if (rdy_low == 0) begin m_tready = 1'b1; m_hold = 1'b0; end
      end
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 31; i >= 0; i--) send_bit(w[i]);
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) send_bit(v[i]);
  endtask

  task automatic send_frame(input logic [31:0] sw, input logic [7:0] base, input bit rnd);
    logic [7:0] v;
    send_word(sw);
    for (int k = 0; k < N; k++) begin
      v = rnd ? 8'($urandom) : base + 8'(k);
      send_byte(v);
    end
  endtask

  function automatic logic [31:0] flip(input int n);
    logic [31:0] f;
    f = '0;
    while ($countones(f) < n) f[$urandom_range(0, 31)] = 1'b1;
    return f;
  endfunction

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_tdata"}, {24'd0, m_tdata}, 32'd0);
    chk({tag, "_tvalid"}, {31'd0, m_tvalid}, 32'd0);
    chk({tag, "_tuser"}, {31'd0, m_tuser}, 32'd0);
    chk({tag, "_tlast"}, {31'd0, m_tlast}, 32'd0);
    chk({tag, "_locked"}, {31'd0, locked}, 32'd0);
    chk({tag, "_inverted"}, {31'd0, inverted}, 32'd0);
    chk({tag, "_frame_cnt"}, {16'd0, frame_cnt}, 32'd0);
    chk({tag, "_ovf"}, {31'd0, ovf}, 32'd0);
  endtask

  // Scoreboard monitor: one pop per accepted beat.
  always @(negedge clk) begin
    if (rst_n && m_tvalid && m_tready) begin
      if (expq.size() == 0) begin
        total++; bad++;
        $display("FAIL unexpected_beat: got %0h user=%0b last=%0b", m_tdata, m_tuser, m_tlast);
      end else begin
        beat_t e;
        e = expq.pop_front();
        chk("beat", {22'd0, m_tdata, m_tuser, m_tlast}, {22'd0, e});
      end
    end
  end

  logic [15:0] saved_fc;

  initial begin
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("rst");
    rst_n = 1'b1;

    // Clean frame after random preamble
    repeat (40) send_bit(1'($urandom_range(0, 1)));
    send_frame(SYNC, 8'h00, 1'b0);
    chk("clean_cnt", {16'd0, frame_cnt}, 32'd1);

    // Error tolerance: 2 flips lock, 3 flips do not
    gap = 10;
    send_frame(SYNC ^ flip(2), 8'h00, 1'b1);
    saved_fc = m_fc;
    send_word(SYNC ^ flip(3));
    repeat (64) send_bit(1'b0);
    chk("err3_cnt", {16'd0, frame_cnt}, {16'd0, saved_fc});
    chk("err3_unlocked", {31'd0, locked}, 32'd0);

    // Backpressure: ~300 clocks of tready low across bytes 0 and 1
    gap = 16;
    send_word(SYNC);
    m_tready = 1'b0; rdy_low = 19;
    for (int k = 0; k < N; k++) send_byte(8'h40 + 8'(k));
    chk("ovf_set", {31'd0, ovf}, 32'd1);
    repeat (50) @(posedge clk);
    #1;
    chk("ovf_sticky", {31'd0, ovf}, 32'd1);

    // Inverted sync with complemented payload
    gap = 12;
    send_word(~SYNC);
    send_byte(~8'hA5);
`ifdef RX_FRAME_INV_DET_EN
    chk("inv_flag", {31'd0, inverted}, 32'd1);
    for (int k = 1; k < N; k++) send_byte(~(8'h60 + 8'(k)));
`else
    chk("noinv_unlocked", {31'd0, locked}, 32'd0);
    repeat (16) send_bit(1'b0);
`endif

    // Reset right after byte 5 completes, with that byte still pending
    send_word(SYNC);
    for (int k = 0; k < 5; k++) send_byte(8'h10 + 8'(k));
    for (int i = 7; i >= 1; i--) send_bit(i[0]);
    @(posedge clk); #1;
    bit_in = 1'b0; bit_vld = 1'b1;
    @(posedge clk); #1;
    bit_vld = 1'b0;
    chk("pre_rst_valid", {31'd0, m_tvalid}, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk_reset_vals("midrst");
    rst_n = 1'b1;
    model_reset();
    repeat (8) send_bit(1'($urandom_range(0, 1)));
    send_frame(SYNC, 8'h20, 1'b0);
    chk("relock_cnt", {16'd0, frame_cnt}, 32'd1);

    // Back-to-back frames
    gap = 9;
    send_frame(SYNC, 8'h00, 1'b1);
    send_frame(SYNC, 8'h00, 1'b1);
    chk("b2b_cnt", {16'd0, frame_cnt}, 32'd3);

    repeat (20) @(posedge clk);
    #1;
    chk("queue_empty", expq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rx_frame_sync.md
# rx_frame_sync

Receive-side frame synchroniser and deserialiser. It sits after the demodulator's bit decision (BPSK/QPSK slicer plus parallel-to-serial), inside the `clk_32M768` domain. It consumes the recovered serial bit stream qualified by a per-bit strobe and hunts for a 32-bit sync word, tolerating a configurable number of bit errors. Once locked, it packs a fixed-length payload MSB-first into bytes on an AXI-Stream-style byte interface (`tuser` on the first byte, `tlast` on the last). It is the receiving counterpart of the transmitter's framer/serialiser.

## Interface
Clock is `clk_32M768`; reset is `rst_n_32M768`, synchronous and active-low.

Parameters:
- `SYNC_WORD`, default 32'h1ACF_FC1D: sync pattern; the first bit on air is bit 31.
- `SYNC_LEN`, default 32: number of sync bits; range 8..32; the low `SYNC_LEN` bits of `SYNC_WORD` are used.
- `MAX_ERR`, default 2: maximum Hamming distance still accepted as sync; must be < `SYNC_LEN`/2.
- `PAYLOAD_BYTES`, default 16: bytes per frame; range 1..255.

Ports:
- `clk_32M768`, in, 1: system clock.
- `rst_n_32M768`, in, 1: synchronous active-low reset.
- `bit_in`, in, 1: recovered data bit; valid only when `bit_vld`=1.
- `bit_vld`, in, 1: one-cycle strobe per bit; at most one per 8 clocks.
- `m_tdata`, out, 8: payload byte, MSB = earliest bit.
- `m_tvalid`, out, 1: byte valid.
- `m_tready`, in, 1: downstream accept.
- `m_tuser`, out, 1: first byte of the frame.
- `m_tlast`, out, 1: last byte of the frame.
- `locked`, out, 1: high while in PAYLOAD.
- `inverted`, out, 1: the current frame was detected with inverted polarity.
- `frame_cnt`, out, 16: count of sync detections; wraps.
- `ovf`, out, 1: sticky flag, set when a byte is dropped; cleared only by reset.

## Operation
- States are HUNT and PAYLOAD. The reset state is HUNT.
- HUNT:
  - On `bit_vld`, the candidate vector is {sr[SYNC_LEN-2:0], `bit_in`}.
  - `d` = popcount(candidate XOR sync). If `d` ≤ `MAX_ERR`, go to PAYLOAD at that edge, increment `frame_cnt`, and clear the bit and byte counters.
  - Otherwise shift `sr`.
  - `sr` is cleared to 0 on every entry to HUNT, so sync is never found overlapping a payload.
- PAYLOAD:
  - Each `bit_vld` shifts `bit_in` (XOR `inverted`) into the byte register.
  - On the 8th bit, the byte is loaded into the output register.
  - After the last bit of byte `PAYLOAD_BYTES`-1, return to HUNT at that edge.
- Output register is a single entry:
  - `m_tvalid` is held until `m_tvalid & m_tready`.
  - If a new byte completes while `m_tvalid`=1 and `m_tready`=0, the new byte is dropped and `ovf` is set. The held byte is kept.
  - If the byte completes in the same cycle as the handshake, the new byte replaces it with no loss.
- `m_tuser`=1 with byte index 0; `m_tlast`=1 with index `PAYLOAD_BYTES`-1. With `PAYLOAD_BYTES`=1 both are high together.
- `bit_vld` while the byte register is being loaded has no conflict: one bit is handled per strobe.

## Timing
- Sync decision is combinational on the strobe cycle; `locked` rises 1 clock after the `bit_vld` carrying the final sync bit.
- Byte latency: `m_tvalid` rises 1 clock after the `bit_vld` carrying a byte's 8th bit.
- `locked` falls 1 clock after the `bit_vld` carrying the final payload bit.
- Reset values:
  - `m_tdata` = 0, `m_tvalid` = 0, `m_tuser` = 0, `m_tlast` = 0.
  - `locked` = 0, `inverted` = 0, `frame_cnt` = 0, `ovf` = 0.
  - `sr` and all counters = 0.
- Reset mid-frame: all of the above take their reset values at the next edge, and a pending byte is discarded.
- `frame_cnt` wraps from 16'hFFFF to 0.

## Configuration
- `RX_FRAME_INV_DET_EN` defined:
  - HUNT also tests popcount(candidate XOR ~sync) ≤ `MAX_ERR`.
  - An inverted match sets `inverted`=1 for the whole frame, and payload bits are complemented before packing. This resolves the BPSK/QPSK 180° phase ambiguity.
  - A true match has priority and sets `inverted`=0.
- Not defined: only true-polarity matches are detected, and `inverted` is tied to 0.

## Structure
- Shared package `rx_frame_pkg`:
  - default `SYNC_WORD` and `SYNC_LEN`;
  - state enum {HUNT, PAYLOAD};
  - `popcount` function.
- Sub-module `sync_correlator`:
  - holds the shift register and the Hamming-distance compare(s);
  - outputs `match` and `match_inv`.
- The top level holds the FSM, deserialiser, output register and status.

## Test plan
- **Clean frame.** Stimulus: 40 random bits, then 1ACFFC1D, then bytes 00..0F, one strobe per 16 clocks, `m_tready`=1. Required:
  - 16 bytes 00..0F;
  - `m_tuser` on 00 and `m_tlast` on 0F;
  - `frame_cnt`=1;
  - `locked` rises 1 clock after the final sync strobe.
- **Error tolerance.** Stimulus: sync with 2 bits flipped, then with 3 bits flipped. Required: the first locks; the second produces no output and `frame_cnt` is unchanged.
- **Backpressure.** Stimulus: `m_tready`=0 for 300 clocks during payload at 16 clocks/bit. Required:
  - the first byte is held;
  - a following byte is dropped;
  - `ovf`=1 and stays 1.
- **Inversion** (with `RX_FRAME_INV_DET_EN`). Stimulus: ~1ACFFC1D followed by complemented payload A5. Required:
  - `inverted`=1, `m_tdata`=A5;
  - without the macro, no lock.
- **Reset mid-frame.** Stimulus: drive `rst_n_32M768`=0 for 1 clock after byte 5. Required:
  - all outputs at reset values next edge;
  - a new sync relocks correctly.
- **Back-to-back frames.** Stimulus: two frames with no gap. Required: both frames are received and `frame_cnt`=2.
